// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx: UART serialiser, transmit half of the uart_rx link.
//
// Takes one PAYLOAD_BITS word per valid/ready handshake and shifts it out on
// TX_D_O as a start bit, the data LSB first, an optional parity bit and
// STOP_BITS stop bits. It can also hold the line low to send a break. Every bit
// lasts CPB = CLK_HZ / BIT_RATE clock cycles.
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data
// bits. PARITY_ODD selects odd (1) or even (0) parity.
//
// Ports:
//   CLK_I       in   system clock, rising edge
//   RST_N_I     in   asynchronous active-low reset
//   TX_EN_I     in   1 = new frames may be accepted
//   TX_VLD_I    in   TX_D_I holds a word to send
//   TX_D_I      in   word to send (PAYLOAD_BITS)
//   TX_BREAK_I  in   request a line break (hold the line low)
//   TX_RDY_O    out  a word can be accepted this cycle (combinational)
//   TX_BUSY_O   out  a frame or break is in progress
//   TX_D_O      out  serial line, idle high, driven from a flop
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 27_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                    CLK_I,
    input  logic                    RST_N_I,
    input  logic                    TX_EN_I,
    input  logic                    TX_VLD_I,
    input  logic [PAYLOAD_BITS-1:0] TX_D_I,
    input  logic                    TX_BREAK_I,
    output logic                    TX_RDY_O,
    output logic                    TX_BUSY_O,
    output logic                    TX_D_O
);

    localparam int CPB = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 1 + PAYLOAD_BITS + 1 + STOP_BITS;
`else
    localparam int FRAME_BITS = 1 + PAYLOAD_BITS + STOP_BITS;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;
    localparam int CNT_W     = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int BRK_W     = $clog2(FRAME_CYC);
    localparam int BITS_W    = 4;

    if (CPB < 2 || PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
        $error("uart_tx: illegal parameters (CPB must be >= 2)");
    end

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;
    localparam logic [2:0] MARK   = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;    // cycle within the current bit
    logic [BITS_W-1:0]       bits_q, bits_d;  // bit index within DATA / STOP
    logic [BRK_W-1:0]        brk_q, brk_d;    // break length, saturates at one frame
    logic [PAYLOAD_BITS-1:0] sh_q, sh_d;
    logic                    tx_q, tx_d;
    logic                    bit_end;
`ifdef UART_TX_PARITY_EN
    logic                    par_q, par_d;
`endif

    assign TX_RDY_O  = (state_q == IDLE) & TX_EN_I & ~TX_BREAK_I & RST_N_I;
    assign TX_BUSY_O = (state_q != IDLE);
    assign TX_D_O    = tx_q;
    assign bit_end   = (cnt_q == CNT_W'(CPB - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
        bits_d  = bits_q;
        brk_d   = brk_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bits_d = '0;
                tx_d   = 1'b1;
                // Break wins over a pending word in the same cycle.
                if (TX_BREAK_I) begin
                    state_d = BREAK;
                    tx_d    = 1'b0;
                    brk_d   = '0;
                end else if (TX_VLD_I && TX_RDY_O) begin
                    // Start bit goes out on the transfer edge itself.
                    state_d = START;
                    tx_d    = 1'b0;
                    sh_d    = TX_D_I;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^TX_D_I) ^ PARITY_ODD[0];
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                    bits_d  = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bits_q == BITS_W'(PAYLOAD_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                        bits_d  = '0;
                    end else begin
                        tx_d   = sh_q[0];
                        sh_d   = sh_q >> 1;
                        bits_d = bits_q + BITS_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    bits_d  = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bits_q == BITS_W'(STOP_BITS - 1)) state_d = IDLE;
                    else                                  bits_d  = bits_q + BITS_W'(1);
                end
            end
            BREAK: begin
                // brk_q reaching FRAME_CYC-1 means a full frame time has elapsed.
                if (brk_q != BRK_W'(FRAME_CYC - 1)) begin
                    brk_d = brk_q + BRK_W'(1);
                end else if (!TX_BREAK_I) begin
                    state_d = MARK;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            MARK: begin
                if (bit_end) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            brk_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            brk_q   <= brk_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int CPB = 9;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    // kind: 0 = data frame, 1 = break, 2 = frame abandoned by reset
    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       par;
        int         len;
    } exp_t;

    logic       CLK_I = 0, RST_N_I = 0, TX_EN_I = 0, TX_VLD_I = 0, TX_BREAK_I = 0;
    logic [7:0] TX_D_I = '0;
    logic       TX_RDY_O, TX_BUSY_O, TX_D_O;

    int   checks = 0, errors = 0, cyc = 0;
    exp_t exp_q[$];
    int   xfer_q[$];
    bit   mon_busy = 0;

    uart_tx #(.BIT_RATE(3_000_000), .CLK_HZ(27_000_000), .PAYLOAD_BITS(8),
              .STOP_BITS(1), .PARITY_ODD(0)) dut (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I), .TX_EN_I(TX_EN_I), .TX_VLD_I(TX_VLD_I),
        .TX_D_I(TX_D_I), .TX_BREAK_I(TX_BREAK_I), .TX_RDY_O(TX_RDY_O),
        .TX_BUSY_O(TX_BUSY_O), .TX_D_O(TX_D_O));

    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) begin
        cyc <= cyc + 1;
        if (RST_N_I && TX_VLD_I && TX_RDY_O) xfer_q.push_back(cyc);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: decodes the serial line, pops the scoreboard, compares.
    initial begin : monitor
        logic [FB-1:0] samp;
        logic [7:0]    d;
        bit            ab;
        int            low;
        exp_t          e;
        forever begin
            @(negedge CLK_I);
            if (RST_N_I && TX_D_O === 1'b0) begin
                mon_busy = 1;
                ab = 0;
                samp = '0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge CLK_I);
                    if (!RST_N_I) begin ab = 1; break; end
                    if (k % CPB == CPB / 2) samp[k / CPB] = TX_D_O;
                end
                low = 0;
                if (!ab && samp == '0) begin
                    low = FRAME;
                    while (TX_D_O === 1'b0 && low < 5000) begin
                        @(negedge CLK_I);
                        if (TX_D_O === 1'b0) low++;
                    end
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL monitor: line activity with empty scoreboard");
                end else begin
                    e = exp_q.pop_front();
                    if (ab) begin
                        check("kind_abort", 2, e.kind);
                    end else if (samp == '0) begin
                        check("kind_break", 1, e.kind);
                        check("break_len", low, e.len);
                    end else begin
                        d = samp[8:1];
                        check("kind_frame", 0, e.kind);
                        check("start_bit", int'(samp[0]), 0);
                        check("data", int'(d), int'(e.data));
`ifdef UART_TX_PARITY_EN
                        check("parity", int'(samp[9]), int'(e.par));
`endif
                        check("stop_bit", int'(samp[FB-1]), 1);
                    end
                end
                if (ab) wait (RST_N_I);
                mon_busy = 0;
            end
        end
    end

    task automatic push(input int kind, input logic [7:0] d, input logic p, input int len);
        exp_t e;
        e.kind = kind; e.data = d; e.par = p; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input logic p, input int kind);
        int n;
        push(kind, d, p, 0);
        n = 0;
        while (!TX_RDY_O && n < 1000) begin @(negedge CLK_I); n++; end
        if (n >= 1000) begin checks++; errors++; $display("FAIL send_rdy: RDY never rose"); end
        TX_D_I = d;
        TX_VLD_I = 1;
        @(posedge CLK_I); #1;
        TX_VLD_I = 0;
        check("start_on_xfer", int'(TX_D_O), 0);
        check("busy_on_xfer", int'(TX_BUSY_O), 1);
    endtask

    // Counts negedges with RDY low until it rises.
    task automatic wait_rdy(output int n);
        n = 0;
        forever begin
            @(negedge CLK_I);
            if (TX_RDY_O === 1'b1 || n >= 2000) break;
            n++;
        end
    endtask

    initial begin : stim
        int n, base;
        TX_EN_I = 1;
        repeat (3) @(negedge CLK_I);
        check("rst_txd", int'(TX_D_O), 1);
        check("rst_busy", int'(TX_BUSY_O), 0);
        check("rst_rdy", int'(TX_RDY_O), 0);
        RST_N_I = 1;
        @(negedge CLK_I);
        check("idle_rdy", int'(TX_RDY_O), 1);
        check("idle_txd", int'(TX_D_O), 1);
        check("idle_busy", int'(TX_BUSY_O), 0);

        // Single frames; parity bits 0xA5 -> 0, 0x01 -> 1
        send(8'hA5, 1'b0, 0);
        wait_rdy(n);
        check("rdy_low_a5", n, FRAME);
        send(8'h01, 1'b1, 0);
        wait_rdy(n);
        check("rdy_low_01", n, FRAME);

        // Back-to-back with VLD held; data changed mid-frame must be ignored
        push(0, 8'h00, 1'b0, 0);
        push(0, 8'hFF, 1'b0, 0);
        base = xfer_q.size();
        TX_D_I = 8'h00;
        TX_VLD_I = 1;
        n = 0;
        while (xfer_q.size() < base + 1 && n < 500) begin @(negedge CLK_I); n++; end
        TX_D_I = 8'hFF;
        n = 0;
        while (xfer_q.size() < base + 2 && n < 500) begin @(negedge CLK_I); n++; end
        TX_VLD_I = 0;
        check("b2b_xfers", xfer_q.size() - base, 2);
        if (xfer_q.size() >= base + 2)
            check("b2b_period", xfer_q[base+1] - xfer_q[base], FRAME + 1);
        wait_rdy(n);

        // Break with VLD raised in the same cycle: no transfer, 200 low, 9 mark
        push(1, 8'h00, 1'b0, 200);
        base = xfer_q.size();
        TX_BREAK_I = 1;
        TX_VLD_I = 1;
        TX_D_I = 8'h77;
        @(posedge CLK_I); #1;
        check("brk_txd", int'(TX_D_O), 0);
        check("brk_busy", int'(TX_BUSY_O), 1);
        repeat (200) @(negedge CLK_I);
        check("brk_rdy", int'(TX_RDY_O), 0);
        TX_BREAK_I = 0;
        TX_VLD_I = 0;
        wait_rdy(n);
        check("brk_mark_len", n, CPB);
        check("brk_no_xfer", xfer_q.size() - base, 0);
        check("brk_line_hi", int'(TX_D_O), 1);

        // Reset in the 4th data bit of 0x3C, then 0x55 intact
        send(8'h3C, 1'b0, 2);
        repeat (40) @(negedge CLK_I);
        #2 RST_N_I = 0;
        #1;
        check("arst_txd", int'(TX_D_O), 1);
        check("arst_busy", int'(TX_BUSY_O), 0);
        check("arst_rdy", int'(TX_RDY_O), 0);
        repeat (3) @(negedge CLK_I);
        RST_N_I = 1;
        @(negedge CLK_I);
        check("post_rst_rdy", int'(TX_RDY_O), 1);
        send(8'h55, 1'b0, 0);
        wait_rdy(n);
        check("rdy_low_55", n, FRAME);

        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin @(negedge CLK_I); n++; end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d frames still expected", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
